matrix_reader: RTL and testbench

- Read-side counterpart to the matrix BRAM write path.
- Given a matrix_id, fetches the 3-word metadata header (rows/cols, name high, name low) from that matrix's BRAM block, then streams the rows*cols data words in row-major order on a valid/ready interface.
- Sits between the matrix BRAM read port and consumers such as the compute engine and display/UART formatter.

---
 rtl/matrix_reader.sv | 158 +++++++++++++++
 tb/tb_matrix_reader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_reader.sv
// matrix_reader: fetches a matrix's 3-word header from its BRAM slot, then streams rows*cols words.
// Optional build macro MATRIX_READER_DIM_CHECK_EN adds dim_error and rejects empty/oversized headers.
module matrix_reader #(
  parameter int BLOCK_SIZE = 1152,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_request,
  input  logic [2:0]            matrix_id,
  output logic                  reader_ready,
  output logic                  meta_valid,
  output logic [7:0]            actual_rows,
  output logic [7:0]            actual_cols,
  output logic [0:7][7:0]       matrix_name,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  read_done,
  output logic                  bram_rd_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout
`ifdef MATRIX_READER_DIM_CHECK_EN
  ,
  output logic                  dim_error
`endif
);
  typedef enum logic [1:0] {IDLE, META, STREAM, DONE} state_e;

  function automatic logic [ADDR_WIDTH-1:0] matrix_address_getter(input logic [2:0] id);
    return ADDR_WIDTH'(int'(id) * BLOCK_SIZE);
  endfunction

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      base_q;
  logic [1:0]                 mcnt_q, mret_q;
  logic                       rvld_q;
  logic [15:0]                hdr_rc_q;
  logic [31:0]                hdr_nm_q;
  logic [7:0]                 rows_q, cols_q;
  logic [0:7][7:0]            name_q;
  logic                       meta_valid_q;
  logic [15:0]                issued_q;
  logic [1:0][DATA_WIDTH-1:0] fifo_q;
  logic                       wptr_q, rptr_q;
  logic [1:0]                 cnt_q;

  logic                  accept, meta_rd, meta_last, pop, push, issue, stream_end;
  logic [2:0]            occ;
  logic [15:0]           total, total_eff;
  logic [ADDR_WIDTH-1:0] off;

  assign total = 16'(rows_q) * 16'(cols_q);

`ifdef MATRIX_READER_DIM_CHECK_EN
  logic dim_q, bad_hdr;
  assign bad_hdr   = (hdr_rc_q[15:8] == 8'd0) || (hdr_rc_q[7:0] == 8'd0) ||
                     ((16'(hdr_rc_q[15:8]) * 16'(hdr_rc_q[7:0])) > 16'(BLOCK_SIZE - 3));
  assign total_eff = dim_q ? 16'd0 : total;
  assign dim_error = dim_q;
`else
  assign total_eff = total;
`endif

  assign accept     = (state_q == IDLE) && read_request;
  assign meta_rd    = (state_q == META) && (mcnt_q != 2'd3);
  assign meta_last  = (state_q == META) && rvld_q && (mret_q == 2'd2);
  assign data_valid = (cnt_q != 2'd0);
  assign data_out   = fifo_q[rptr_q];
  assign pop        = data_valid && data_ready;
  assign push       = (state_q == STREAM) && rvld_q;
  // Occupancy after this edge: words held plus the one landing now, minus the one leaving.
  assign occ        = 3'(cnt_q) + 3'(push) - 3'(pop);
  assign issue      = (state_q == STREAM) && (issued_q < total_eff) && (occ < 3'd2);
  assign stream_end = (state_q == STREAM) && (issued_q == total_eff) && !rvld_q && (occ == 3'd0);

  assign off        = meta_rd ? ADDR_WIDTH'(mcnt_q) : ADDR_WIDTH'(issued_q) + ADDR_WIDTH'(3);
  assign bram_rd_en = meta_rd || issue;
  assign bram_addr  = bram_rd_en ? base_q + off : '0;

  assign reader_ready = (state_q == IDLE);
  assign read_done    = (state_q == DONE);
  assign meta_valid   = meta_valid_q;
  assign actual_rows  = rows_q;
  assign actual_cols  = cols_q;
  assign matrix_name  = name_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (read_request) state_d = META;
      META:    if (meta_last)    state_d = STREAM;
      STREAM:  if (stream_end)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      mcnt_q       <= '0;
      mret_q       <= '0;
      rvld_q       <= 1'b0;
      hdr_rc_q     <= '0;
      hdr_nm_q     <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      name_q       <= '0;
      meta_valid_q <= 1'b0;
      issued_q     <= '0;
      fifo_q       <= '0;
      wptr_q       <= 1'b0;
      rptr_q       <= 1'b0;
      cnt_q        <= '0;
`ifdef MATRIX_READER_DIM_CHECK_EN
      dim_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rvld_q       <= bram_rd_en;
      meta_valid_q <= meta_last;
      if (accept) begin
        base_q   <= matrix_address_getter(matrix_id);
        mcnt_q   <= '0;
        mret_q   <= '0;
        issued_q <= '0;
`ifdef MATRIX_READER_DIM_CHECK_EN
        dim_q    <= 1'b0;
`endif
      end
      if (meta_rd) mcnt_q <= mcnt_q + 2'd1;
      if ((state_q == META) && rvld_q) begin
        mret_q <= mret_q + 2'd1;
        if (mret_q == 2'd0) hdr_rc_q <= bram_dout[31:16];
        if (mret_q == 2'd1) hdr_nm_q <= bram_dout[31:0];
      end
      // Visible header fields only change together with the meta_valid pulse.
      if (meta_last) begin
        rows_q <= hdr_rc_q[15:8];
        cols_q <= hdr_rc_q[7:0];
        name_q <= {hdr_nm_q, bram_dout[31:0]};
`ifdef MATRIX_READER_DIM_CHECK_EN
        dim_q  <= bad_hdr;
`endif
      end
      if (issue) issued_q <= issued_q + 16'd1;
      if (push) begin
        fifo_q[wptr_q] <= bram_dout;
        wptr_q         <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_matrix_reader.sv
// Bench for matrix_reader: BRAM array model plus a per-request reference that predicts header,
// data sequence, handshake timing and read addresses, compared every cycle at the falling edge.
`timescale 1ns/1ps
module tb_matrix_reader;
  localparam int BS = 1152;

  logic clk = 1'b0, rst_n = 1'b0, read_request = 1'b0, data_ready = 1'b1;
  logic [2:0] matrix_id = 3'd0;
  logic reader_ready, meta_valid, data_valid, read_done, bram_rd_en;
  logic [7:0] actual_rows, actual_cols;
  logic [0:7][7:0] matrix_name;
  logic [31:0] data_out, bram_dout;
  logic [13:0] bram_addr;
`ifdef MATRIX_READER_DIM_CHECK_EN
  logic dim_error;
`endif

  always #5 clk = ~clk;

  matrix_reader dut (
    .clk(clk), .rst_n(rst_n), .read_request(read_request), .matrix_id(matrix_id),
    .reader_ready(reader_ready), .meta_valid(meta_valid), .actual_rows(actual_rows),
    .actual_cols(actual_cols), .matrix_name(matrix_name), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .read_done(read_done),
    .bram_rd_en(bram_rd_en), .bram_addr(bram_addr), .bram_dout(bram_dout)
`ifdef MATRIX_READER_DIM_CHECK_EN
    , .dim_error(dim_error)
`endif
  );

  logic [31:0] mem [0:16383];
  always @(posedge clk) if (bram_rd_en) bram_dout <= mem[bram_addr];

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference state for the request currently in flight
  int cyc = 0, acc_cyc = 0, done_cyc = -1, nreads = 0, npop = 0, e_total = 0;
  int first_dv_cyc = -1, first_pop_cyc = -1, last_pop_cyc = -1, nreads_final = 0;
  bit busy = 0, dim_cur = 0, prev_stall = 0, e_err = 0;
  logic [31:0] prev_do;
  logic [13:0] base_m;
  logic [7:0]  e_rows, e_cols;
  logic [63:0] e_name;
  logic [31:0] expq[$], got_q[$];

  always @(negedge clk) begin : mon
    int b, r, c;
    bit was_busy;
    logic [31:0] w;
    cyc++;
    if (!rst_n) begin
      chk("rst_ready", reader_ready, 1);
      chk("rst_meta_valid", meta_valid, 0);
      chk("rst_data_valid", data_valid, 0);
      chk("rst_read_done", read_done, 0);
      chk("rst_rd_en", bram_rd_en, 0);
      chk("rst_addr", bram_addr, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_rows", actual_rows, 0);
      chk("rst_cols", actual_cols, 0);
      chk("rst_name", matrix_name, 0);
`ifdef MATRIX_READER_DIM_CHECK_EN
      chk("rst_dim_error", dim_error, 0);
`endif
      busy = 0; dim_cur = 0; prev_stall = 0; done_cyc = -1;
      expq.delete();
    end else begin
      was_busy = busy;
      chk("ready", reader_ready, !was_busy);
      chk("meta_valid", meta_valid, was_busy && (cyc == acc_cyc + 5));
      if (was_busy && cyc == acc_cyc + 1) dim_cur = 0;
      if (was_busy && cyc == acc_cyc + 5) dim_cur = e_err;
`ifdef MATRIX_READER_DIM_CHECK_EN
      chk("dim_error", dim_error, dim_cur);
`endif
      if (meta_valid) begin
        chk("rows", actual_rows, e_rows);
        chk("cols", actual_cols, e_cols);
        chk("name", matrix_name, e_name);
      end
      chk("read_done", read_done, was_busy && (cyc == done_cyc));
      if (was_busy && cyc >= acc_cyc + 1 && cyc <= acc_cyc + 4)
        chk("meta_rd_en", bram_rd_en, cyc != acc_cyc + 4);
      else if (!was_busy)
        chk("idle_rd_en", bram_rd_en, 0);
      if (bram_rd_en) begin
        chk("rd_addr", bram_addr, 14'(int'(base_m) + nreads));
        nreads++;
      end
      if (prev_stall) begin
        chk("stall_valid", data_valid, 1);
        chk("stall_data", data_out, prev_do);
      end
      if (data_valid && was_busy && first_dv_cyc < 0) first_dv_cyc = cyc;
      if (data_valid && expq.size() == 0) chk("dv_unexpected", data_valid, 0);
      else if (data_valid && data_ready) begin
        w = expq.pop_front();
        chk("data", data_out, w);
        got_q.push_back(data_out);
        npop++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        if (expq.size() == 0) done_cyc = cyc + 1;
      end
      if (was_busy && cyc > acc_cyc + 4) chk("reads_ahead", (nreads - 3 - npop) <= 2, 1);
      prev_stall = data_valid && !data_ready;
      prev_do    = data_out;
      if (was_busy && cyc == done_cyc) begin
        chk("nreads", nreads, 3 + e_total);
        nreads_final = nreads;
        busy = 0;
      end
      if (!was_busy && read_request) begin
        b = int'(matrix_id) * BS;
        base_m = 14'(b);
        r = int'(mem[b][31:24]);
        c = int'(mem[b][23:16]);
        e_rows = mem[b][31:24];
        e_cols = mem[b][23:16];
        e_name = {mem[b+1], mem[b+2]};
`ifdef MATRIX_READER_DIM_CHECK_EN
        e_err = (r == 0) || (c == 0) || (r * c > BS - 3);
`else
        e_err = 0;
`endif
        e_total = e_err ? 0 : r * c;
        expq.delete();
        got_q.delete();
        for (int i = 0; i < e_total; i++) expq.push_back(mem[(b + 3 + i) % 16384]);
        acc_cyc = cyc; nreads = 0; npop = 0;
        first_dv_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
        done_cyc = (e_total == 0) ? cyc + 6 : -1;
        busy = 1;
      end
    end
  end

  // data_ready pattern: 0 = always 1, 1 = 1,0,0,1 repeating, 2 = random
  int dr_mode = 0, dr_k = 0;
  initial forever begin
    @(posedge clk); #1;
    case (dr_mode)
      0:       data_ready = 1'b1;
      1:       data_ready = (dr_k % 4 == 0) || (dr_k % 4 == 3);
      default: data_ready = 1'($urandom_range(0, 1));
    endcase
    dr_k++;
  end

  task automatic load(input int slot, input int r, input int c, input logic [63:0] nm, input int mode);
    int b;
    b = slot * BS;
    mem[b]     = {r[7:0], c[7:0], 16'd0};
    mem[b + 1] = nm[63:32];
    mem[b + 2] = nm[31:0];
    if (mode != 2)
      for (int i = 0; i < r * c; i++) mem[b + 3 + i] = (mode == 1) ? $urandom : 32'(i + 1);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(posedge clk);
    while (busy && n < 3000) begin @(posedge clk); n++; end
    chk(nm, busy, 0);
    #1;
  endtask

  task automatic do_read(input logic [2:0] id);
    wait_idle("wait_idle_before_req");
    read_request = 1'b1;
    matrix_id    = id;
    @(posedge clk); #1;
    read_request = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int s, r, c, n;
    for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic read, consumer always ready
    load(1, 2, 3, "MATRIX_A", 0);
    load(2, 3, 3, "OTHER_MX", 1);
    do_read(3'd1);
    wait_idle("t1_done");
    chk("t1_first_dv", 64'(first_dv_cyc - acc_cyc), 7);
    chk("t1_span", 64'(last_pop_cyc - first_pop_cyc), 5);
    chk("t1_nwords", got_q.size(), 6);
    for (int i = 0; i < got_q.size(); i++) chk("t1_word", got_q[i], 64'(i + 1));
    chk("t1_rows", actual_rows, 8'd2);
    chk("t1_cols", actual_cols, 8'd3);
    chk("t1_name", matrix_name, "MATRIX_A");
    chk("t1_ready_after", reader_ready, 1);

    // Stalling consumer
    dr_k = 0; dr_mode = 1;
    do_read(3'd1);
    wait_idle("t2_done");
    chk("t2_nwords", got_q.size(), 6);
    for (int i = 0; i < got_q.size(); i++) chk("t2_word", got_q[i], 64'(i + 1));

    // Zero rows: header only
    dr_mode = 0;
    load(3, 0, 5, "ZEROROWS", 1);
    do_read(3'd3);
    wait_idle("t3_done");
    chk("t3_nreads", nreads_final, 3);
    chk("t3_no_dv", first_dv_cyc == -1, 1);

    // Request during stream must be ignored
    dr_mode = 2;
    do_read(3'd1);
    repeat (8) @(posedge clk);
    #1 read_request = 1'b1; matrix_id = 3'd2;
    @(posedge clk); #1 read_request = 1'b0;
    wait_idle("t4_done");
    chk("t4_nwords", got_q.size(), 6);
    for (int i = 0; i < got_q.size(); i++) chk("t4_word", got_q[i], 64'(i + 1));

    // Reset during the third data word, then read slot 0
    dr_mode = 0;
    load(0, 1, 4, "SLOTZERO", 1);
    do_read(3'd1);
    n = 0;
    while (npop < 2 && n < 100) begin @(posedge clk); n++; end
    chk("t5_reached_word3", npop >= 2, 1);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_read(3'd0);
    wait_idle("t5_done");
    chk("t5_nwords", got_q.size(), 4);
    chk("t5_name", matrix_name, "SLOTZERO");

`ifdef MATRIX_READER_DIM_CHECK_EN
    load(4, 40, 40, "TOOLARGE", 2);
    do_read(3'd4);
    wait_idle("t6_done");
    chk("t6_nreads", nreads_final, 3);
    chk("t6_dim_hold", dim_error, 1);
`endif

    // Randomized matrices
    for (int t = 0; t < 10; t++) begin
      s = $urandom_range(0, 7);
      r = $urandom_range(0, 4);
      c = $urandom_range(0, 4);
      load(s, r, c, {$urandom, $urandom}, 1);
      dr_mode = 2;
      do_read(3'(s));
      wait_idle("rand_done");
      chk("rand_nwords", got_q.size(), r * c);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
